// File: rtl/im_boot_loader.sv
// im_boot_loader: byte-stream program loader for the single-cycle core.
// Holds the core in reset, receives a little-endian image
// (word count N, N instruction words, one XOR checksum byte) over a
// valid/ready byte handshake, writes each assembled word into
// instruction memory from word 0 upward, and releases the core only
// when the checksum matches.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_byte_valid  stream byte present
//   i_byte_data   stream byte
//   o_byte_ready  loader accepts a byte (transfer on valid & ready)
//   o_IM_wen      one-cycle instruction memory write strobe
//   o_IM_waddr    byte address of the write (word_index*4)
//   o_IM_wd       instruction word to write
//   o_core_rstn   active-low core reset, 1 once the image is verified
//   o_done        image loaded and verified
//   o_error       load failed, sticky until i_rst
module im_boot_loader #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte_data,
  output logic                 o_byte_ready,
  output logic                 o_IM_wen,
  output logic [WORD_SIZE-1:0] o_IM_waddr,
  output logic [WORD_SIZE-1:0] o_IM_wd,
  output logic                 o_core_rstn,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int unsigned IDX_W     = DEPTH_LOG2 + 1;
  localparam int unsigned MAX_WORDS = 2 ** DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state;
  logic [23:0]        shift_q;   // first three bytes of the field being assembled
  logic [1:0]         byte_cnt;  // byte position within the current 4-byte field
  logic [IDX_W-1:0]   word_idx;
  logic [31:0]        len_q;
  logic [7:0]         csum_q;    // XOR of every accepted byte so far

  logic               accept_c;
  logic [31:0]        word_c;
  logic               last_word_c;
  logic               len_bad_c;

  assign accept_c    = i_byte_valid & o_byte_ready;
  // Little-endian: the byte arriving now becomes bits [31:24].
  assign word_c      = {i_byte_data, shift_q};
  assign last_word_c = (32'(word_idx) == (len_q - 32'd1));
  // Full 32-bit header compare so oversized counts cannot alias into range.
  assign len_bad_c   = (word_c == 32'd0) || (word_c > 32'(MAX_WORDS));

  // Loader FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_LEN;
      shift_q      <= '0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      o_byte_ready <= 1'b0;
      o_IM_wen     <= 1'b0;
      o_IM_waddr   <= '0;
      o_IM_wd      <= '0;
      o_core_rstn  <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_IM_wen <= 1'b0;
      case (state)
        S_LEN: begin
          o_byte_ready <= 1'b1;
          if (accept_c) begin
            shift_q  <= word_c[31:8];
            csum_q   <= csum_q ^ i_byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              len_q <= word_c;
              if (len_bad_c) begin
                state        <= S_ERR;
                o_error      <= 1'b1;
                o_byte_ready <= 1'b0;
              end else begin
                state    <= S_DATA;
                word_idx <= '0;
              end
            end
          end
        end

        S_DATA: begin
          if (accept_c) begin
            shift_q  <= word_c[31:8];
            csum_q   <= csum_q ^ i_byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_IM_wen   <= 1'b1;
              o_IM_wd    <= WORD_SIZE'(word_c);
              o_IM_waddr <= WORD_SIZE'({word_idx, 2'b00});
              if (last_word_c) begin
                state <= S_CSUM;
              end else begin
                word_idx <= word_idx + IDX_W'(1);
              end
            end
          end
        end

        S_CSUM: begin
          if (accept_c) begin
            o_byte_ready <= 1'b0;
            if (i_byte_data == csum_q) begin
              state       <= S_DONE;
              o_done      <= 1'b1;
              o_core_rstn <= 1'b1;
            end else begin
              state   <= S_ERR;
              o_error <= 1'b1;
            end
          end
        end

        S_DONE: begin
          o_byte_ready <= 1'b0;
        end

        S_ERR: begin
          o_byte_ready <= 1'b0;
        end

        default: begin
          state        <= S_ERR;
          o_error      <= 1'b1;
          o_byte_ready <= 1'b0;
          o_core_rstn  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: directed + randomized bench for im_boot_loader.
// Images are built as byte lists; expected writes and final status are
// derived from the image contents and the stream format rules.
module tb_im_boot_loader;

  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned DEPTH_LOG2 = 8;
  localparam int unsigned MAX_WORDS  = 256;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_byte_valid = 1'b0;
  logic [7:0]           i_byte_data = 8'h00;
  logic                 o_byte_ready;
  logic                 o_IM_wen;
  logic [WORD_SIZE-1:0] o_IM_waddr;
  logic [WORD_SIZE-1:0] o_IM_wd;
  logic                 o_core_rstn;
  logic                 o_done;
  logic                 o_error;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  stream[$];
  logic [31:0] img[$];
  logic [31:0] cur_n;
  bit          cur_corrupt;
  logic [63:0] got_wr[$];

  always #5 i_clk = ~i_clk;

  im_boot_loader #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_byte_valid(i_byte_valid),
    .i_byte_data (i_byte_data),
    .o_byte_ready(o_byte_ready),
    .o_IM_wen    (o_IM_wen),
    .o_IM_waddr  (o_IM_waddr),
    .o_IM_wd     (o_IM_wd),
    .o_core_rstn (o_core_rstn),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  // Record every cycle with the write strobe high.
  always @(negedge i_clk) begin
    if (!i_rst && o_IM_wen) got_wr.push_back({o_IM_waddr, o_IM_wd});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hdr_ok();
    return (cur_n != 32'd0) && (cur_n <= 32'(MAX_WORDS));
  endfunction

  // Header, payload, then XOR of all preceding bytes (optionally corrupted).
  task automatic make_stream(input logic [31:0] n, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    stream.delete();
    for (int k = 0; k < 4; k++) stream.push_back(n[8*k +: 8]);
    foreach (img[i]) for (int k = 0; k < 4; k++) stream.push_back(img[i][8*k +: 8]);
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(corrupt ? (x ^ 8'h01) : x);
    cur_n       = n;
    cur_corrupt = corrupt;
  endtask

  // Called on a falling edge; asserts reset there and checks it acts at once.
  task automatic do_reset();
    i_rst        = 1'b1;
    i_byte_valid = 1'b0;
    #1;
    check("rst_ready", 64'(o_byte_ready), 64'd0);
    check("rst_wen",   64'(o_IM_wen),     64'd0);
    check("rst_waddr", 64'(o_IM_waddr),   64'd0);
    check("rst_wd",    64'(o_IM_wd),      64'd0);
    check("rst_core",  64'(o_core_rstn),  64'd0);
    check("rst_done",  64'(o_done),       64'd0);
    check("rst_error", 64'(o_error),      64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    // Junk byte offered while ready is still low must be ignored.
    i_byte_valid = 1'b1;
    i_byte_data  = 8'(($urandom % 255) + 1);
    check("ready_low_after_rst", 64'(o_byte_ready), 64'd0);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    check("ready_rise", 64'(o_byte_ready), 64'd1);
    got_wr.delete();
  endtask

  // Send stream bytes with random idle gaps; checks each accepted byte's effect.
  task automatic send(input int idle_max, input int stop_after);
    int j;
    int b;
    int wi;
    bit exp_wen;
    bit term;
    j = 0;
    while (j < stream.size() && j < stop_after) begin
      if (!o_byte_ready) break;
      if (idle_max > 0) begin
        repeat ($urandom_range(0, idle_max)) begin
          i_byte_valid = 1'b0;
          i_byte_data  = 8'($urandom);
          @(negedge i_clk);
        end
      end
      i_byte_valid = 1'b1;
      i_byte_data  = stream[j];
      @(negedge i_clk);
      i_byte_valid = 1'b0;
      b  = j;
      j++;
      wi = (b - 4) / 4;
      exp_wen = hdr_ok() && (b >= 4) && (b < 4 + 4 * int'(cur_n)) && (((b - 4) % 4) == 3);
      check("wen", 64'(o_IM_wen), 64'(exp_wen));
      if (exp_wen) begin
        check("waddr", 64'(o_IM_waddr), 64'(wi * 4));
        check("wdata", 64'(o_IM_wd),    64'(img[wi]));
      end
      term = (!hdr_ok() && b == 3) || (hdr_ok() && b == 4 + 4 * int'(cur_n));
      check("ready_after_byte", 64'(o_byte_ready), 64'(!term));
    end
  endtask

  // Toggle extra ignored bytes, then check final status and the write log.
  task automatic final_check();
    bit exp_done;
    int exp_cnt;
    repeat (4) begin
      i_byte_valid = 1'($urandom);
      i_byte_data  = 8'($urandom);
      @(negedge i_clk);
    end
    i_byte_valid = 1'b0;
    exp_done = hdr_ok() && !cur_corrupt;
    exp_cnt  = hdr_ok() ? int'(cur_n) : 0;
    check("done",  64'(o_done),       64'(exp_done));
    check("error", 64'(o_error),      64'(!exp_done));
    check("core",  64'(o_core_rstn),  64'(exp_done));
    check("ready_final", 64'(o_byte_ready), 64'd0);
    check("wr_count", 64'(got_wr.size()), 64'(exp_cnt));
    for (int i = 0; i < exp_cnt && i < got_wr.size(); i++)
      check("wr_log", got_wr[i], {32'(i * 4), img[i]});
  endtask

  task automatic run_image(input logic [31:0] n, input bit corrupt, input int idle_max);
    make_stream(n, corrupt);
    do_reset();
    send(idle_max, 1 << 20);
    final_check();
  endtask

  task automatic set_good_img();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0050_0093);
  endtask

  initial begin
    logic [31:0] n;
    int r;
    @(negedge i_clk);

    set_good_img();
    run_image(32'd2, 1'b0, 0);
    check("good_csum_byte", 64'(stream[stream.size()-1]), 64'hD2);

    run_image(32'd2, 1'b1, 0);

    img.delete();
    run_image(32'd0, 1'b0, 0);
    run_image(32'd257, 1'b0, 0);

    set_good_img();
    run_image(32'd2, 1'b0, 5);

    // Reset mid-load after 7 bytes, and after 8 (write strobe in flight).
    for (int stop = 7; stop <= 8; stop++) begin
      set_good_img();
      make_stream(32'd2, 1'b0);
      do_reset();
      send(0, stop);
      if (stop == 8) check("inflight_wen", 64'(o_IM_wen), 64'd1);
      do_reset();
      send(0, 1 << 20);
      final_check();
    end

    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(32'(i));
    run_image(32'd256, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      img.delete();
      r = $urandom_range(0, 9);
      if (r == 0) n = 32'd0;
      else if (r == 1) n = 32'd257;
      else if (r == 2) n = 32'h8000_0001;
      else if (r == 3) n = 32'h0000_0200;
      else n = 32'($urandom_range(1, 8));
      if (n <= 32'd8) for (int i = 0; i < int'(n); i++) img.push_back($urandom);
      run_image(n, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
